// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the multiplexed 7-segment scan driver.
//   SEG_BLANK      : all segments off (pre-polarity)
//   SEG_TABLE_DEC  : 16-entry pattern table, codes 10-15 blank
//   SEG_TABLE_HEX  : 16-entry pattern table, codes 10-15 show A,b,C,d,E,F
//   idx_width()    : width of the scan index for a given digit count
// Segment bit order everywhere is {g,f,e,d,c,b,a}, 1 = lit.
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // One displayed "pixel": the segment pattern plus the decimal point.
    typedef struct packed {
        seg_t seg;
        logic dp;
    } disp_pix_t;

    localparam seg_t SEG_BLANK = 7'b000_0000;

    // Packed array: element [c] is the pattern for code c.
    // The concatenation therefore lists code 15 first and code 0 last.
    localparam logic [15:0][6:0] SEG_TABLE_DEC = {
        SEG_BLANK,   // 15
        SEG_BLANK,   // 14
        SEG_BLANK,   // 13
        SEG_BLANK,   // 12
        SEG_BLANK,   // 11
        SEG_BLANK,   // 10
        7'b110_1111, // 9
        7'b111_1111, // 8
        7'b000_0111, // 7
        7'b111_1101, // 6
        7'b110_1101, // 5
        7'b110_0110, // 4
        7'b100_1111, // 3
        7'b101_1011, // 2
        7'b000_0110, // 1
        7'b011_1111  // 0
    };

    localparam logic [15:0][6:0] SEG_TABLE_HEX = {
        7'b111_0001, // F
        7'b111_1001, // E
        7'b101_1110, // d
        7'b011_1001, // C
        7'b111_1100, // b
        7'b111_0111, // A
        7'b110_1111, // 9
        7'b111_1111, // 8
        7'b000_0111, // 7
        7'b111_1101, // 6
        7'b110_1101, // 5
        7'b110_0110, // 4
        7'b100_1111, // 3
        7'b101_1011, // 2
        7'b000_0110, // 1
        7'b011_1111  // 0
    };

    // ceil(log2(n)), never less than 1 so a 2-digit build still has an index bit.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational code-to-segment decoder, shared by all digits (sits after the
// digit mux, so only one copy exists regardless of digit count).
// Ports:
//   code_i     [3:0] digit code
//   hex_mode_i       1: codes 10-15 show A..F, 0: codes 10-15 are blank
//   seg_o      [6:0] {g,f,e,d,c,b,a}, 1 = lit (polarity applied elsewhere)
// -----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       hex_mode_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = hex_mode_i ? SEG_TABLE_HEX[code_i] : SEG_TABLE_DEC[code_i];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// N-digit multiplexed 7-segment scan driver with per-frame shadowing,
// leading-zero blanking, per-digit decimal point and blink, 16-level PWM
// brightness and selectable output polarity.
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   bcd          4*N_DIGITS digit codes, digit 0 (rightmost) in [3:0]
//   dp_in        per-digit decimal point request
//   blink_mask   per-digit blink enable
//   bright       brightness, duty = (bright+1)/16
//   lzb_en       leading-zero blanking enable
//   seg          segments {g,f,e,d,c,b,a}
//   dp           decimal point of the active digit
//   digit_sel    one-hot digit enable
//   frame_start  one-cycle pulse, one cycle after the frame-start state
// seg, dp and digit_sel are inverted when ACTIVE_LOW=1.
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int SCAN_DIV_LOG2  = 17,
    parameter int BLINK_DIV_LOG2 = 25,
    parameter int ACTIVE_LOW     = 0,
    parameter int HEX_MODE       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   bcd,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blink_mask,
    input  logic [3:0]              bright,
    input  logic                    lzb_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     digit_sel,
    output logic                    frame_start
);

    localparam int               IDX_W    = idx_width(N_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic             POL      = (ACTIVE_LOW != 0);
    localparam logic             HEX      = (HEX_MODE != 0);

    // ---------------------------------------------------------------------
    // Timebase: slot counter, scan index, blink counter
    // ---------------------------------------------------------------------
    logic [SCAN_DIV_LOG2-1:0]  slot_q,  slot_d;
    logic [IDX_W-1:0]          idx_q,   idx_d;
    logic [BLINK_DIV_LOG2-1:0] blink_q, blink_d;
    logic                      frame_cyc;

    assign frame_cyc = (idx_q == '0) && (slot_q == '0);

    always_comb begin
        slot_d  = slot_q + 1'b1;
        blink_d = blink_q + 1'b1;
        idx_d   = idx_q;
        if (&slot_q) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Shadow registers. On the frame-start cycle the live inputs are used
    // directly, so the very first slot of a frame already shows the newly
    // captured content and no slot ever mixes old and new frames.
    // ---------------------------------------------------------------------
    logic [4*N_DIGITS-1:0] bcd_sh_q,   bcd_sh_d;
    logic [N_DIGITS-1:0]   dp_sh_q,    dp_sh_d;
    logic [N_DIGITS-1:0]   blink_sh_q, blink_sh_d;
    logic [3:0]            bright_sh_q, bright_sh_d;
    logic                  lzb_sh_q,   lzb_sh_d;

    always_comb begin
        bcd_sh_d    = bcd_sh_q;
        dp_sh_d     = dp_sh_q;
        blink_sh_d  = blink_sh_q;
        bright_sh_d = bright_sh_q;
        lzb_sh_d    = lzb_sh_q;
        if (frame_cyc) begin
            bcd_sh_d    = bcd;
            dp_sh_d     = dp_in;
            blink_sh_d  = blink_mask;
            bright_sh_d = bright;
            lzb_sh_d    = lzb_en;
        end
    end

    // ---------------------------------------------------------------------
    // Leading-zero blanking: digit i blanks when it and every digit above it
    // are zero. Digit 0 is excluded so an all-zero value still shows "0".
    // ---------------------------------------------------------------------
    logic [N_DIGITS-1:0] lz_blank;
    logic                lz_run;

    always_comb begin
        lz_blank = '0;
        lz_run   = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            lz_run      = lz_run & (bcd_sh_d[4*i +: 4] == 4'd0);
            lz_blank[i] = lzb_sh_d & lz_run;
        end
    end

    // ---------------------------------------------------------------------
    // Digit mux
    // ---------------------------------------------------------------------
    logic [3:0]          code_sel;
    logic                dp_sel;
    logic                blink_sel;
    logic                lz_sel;
    logic [N_DIGITS-1:0] onehot;

    always_comb begin
        code_sel  = 4'd0;
        dp_sel    = 1'b0;
        blink_sel = 1'b0;
        lz_sel    = 1'b0;
        onehot    = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                code_sel  = bcd_sh_d[4*i +: 4];
                dp_sel    = dp_sh_d[i];
                blink_sel = blink_sh_d[i];
                lz_sel    = lz_blank[i];
                onehot[i] = 1'b1;
            end
        end
    end

    seg_t seg_dec;

    seg7_decode u_decode (
        .code_i     (code_sel),
        .hex_mode_i (HEX),
        .seg_o      (seg_dec)
    );

    // ---------------------------------------------------------------------
    // Visibility, PWM and output formation
    // ---------------------------------------------------------------------
    logic [3:0] top4;
    logic       pwm_on;
    logic       blink_phase;
    logic       digit_vis;

    assign top4        = slot_q[SCAN_DIV_LOG2-1 -: 4];
    assign pwm_on      = (top4 <= bright_sh_d);
    // Blink phase is deliberately live so a blinking digit keeps a steady
    // cadence independent of frame boundaries.
    assign blink_phase = blink_q[BLINK_DIV_LOG2-1];
    assign digit_vis   = !(blink_sel && blink_phase) && !lz_sel;

    disp_pix_t           pix;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q,  dp_d;
    logic [N_DIGITS-1:0] sel_q, sel_d;
    logic                fs_q,  fs_d;

    always_comb begin
        pix.seg = SEG_BLANK;
        pix.dp  = 1'b0;
        if (pwm_on && digit_vis) begin
            pix.seg = seg_dec;
            pix.dp  = dp_sel;
        end
        // A blanked digit is still selected so every slot has the same timing;
        // only PWM-off time deselects all digits.
        seg_d = pix.seg ^ {7{POL}};
        dp_d  = pix.dp ^ POL;
        sel_d = (pwm_on ? onehot : '0) ^ {N_DIGITS{POL}};
        fs_d  = frame_cyc;
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= '0;
            idx_q       <= '0;
            blink_q     <= '0;
            bcd_sh_q    <= '0;
            dp_sh_q     <= '0;
            blink_sh_q  <= '0;
            bright_sh_q <= '0;
            lzb_sh_q    <= 1'b0;
            seg_q       <= {7{POL}};
            dp_q        <= POL;
            sel_q       <= {N_DIGITS{POL}};
            fs_q        <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            blink_q     <= blink_d;
            bcd_sh_q    <= bcd_sh_d;
            dp_sh_q     <= dp_sh_d;
            blink_sh_q  <= blink_sh_d;
            bright_sh_q <= bright_sh_d;
            lzb_sh_q    <= lzb_sh_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            sel_q       <= sel_d;
            fs_q        <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign digit_sel   = sel_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Two instances share all inputs: dut (active-high, decimal codes only) and
// dut_al (active-low, hex codes). A cycle-count reference model pushes the
// expected output bundle for every clock into a queue; it is popped and
// compared one cycle later, after the registered outputs settle.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int ND = 4;

    logic          clk;
    logic          rst;
    logic [15:0]   bcd;
    logic [ND-1:0] dp_in;
    logic [ND-1:0] blink_mask;
    logic [3:0]    bright;
    logic          lzb_en;

    logic [6:0]    seg,    seg_al;
    logic          dp,     dp_al;
    logic [ND-1:0] digit_sel, digit_sel_al;
    logic          frame_start, frame_start_al;

    seg7_scan_driver #(
        .N_DIGITS(ND), .SCAN_DIV_LOG2(4), .BLINK_DIV_LOG2(8),
        .ACTIVE_LOW(0), .HEX_MODE(0)
    ) dut (
        .clk(clk), .rst(rst), .bcd(bcd), .dp_in(dp_in), .blink_mask(blink_mask),
        .bright(bright), .lzb_en(lzb_en), .seg(seg), .dp(dp),
        .digit_sel(digit_sel), .frame_start(frame_start)
    );

    seg7_scan_driver #(
        .N_DIGITS(ND), .SCAN_DIV_LOG2(4), .BLINK_DIV_LOG2(8),
        .ACTIVE_LOW(1), .HEX_MODE(1)
    ) dut_al (
        .clk(clk), .rst(rst), .bcd(bcd), .dp_in(dp_in), .blink_mask(blink_mask),
        .bright(bright), .lzb_en(lzb_en), .seg(seg_al), .dp(dp_al),
        .digit_sel(digit_sel_al), .frame_start(frame_start_al)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------------
    // Check bookkeeping
    // ---------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    typedef struct packed {
        logic [6:0]    seg;
        logic          dp;
        logic [ND-1:0] sel;
        logic          fs;
        logic [6:0]    seg_al;
        logic          dp_al;
        logic [ND-1:0] sel_al;
        logic          fs_al;
    } exp_t;

    exp_t sb_q[$];

    int            m_t;
    logic [15:0]   sh_bcd;
    logic [ND-1:0] sh_dp, sh_blink;
    logic [3:0]    sh_bright;
    logic          sh_lzb;
    int            last_idx;
    int            last_slot;
    bit            last_fs;

    function automatic logic [6:0] segtab(input logic [3:0] c, input bit hex);
        case (c)
            4'd0:  return 7'h3F;
            4'd1:  return 7'h06;
            4'd2:  return 7'h5B;
            4'd3:  return 7'h4F;
            4'd4:  return 7'h66;
            4'd5:  return 7'h6D;
            4'd6:  return 7'h7D;
            4'd7:  return 7'h07;
            4'd8:  return 7'h7F;
            4'd9:  return 7'h6F;
            4'd10: return hex ? 7'h77 : 7'h00;
            4'd11: return hex ? 7'h7C : 7'h00;
            4'd12: return hex ? 7'h39 : 7'h00;
            4'd13: return hex ? 7'h5E : 7'h00;
            4'd14: return hex ? 7'h79 : 7'h00;
            default: return hex ? 7'h71 : 7'h00;
        endcase
    endfunction

    task automatic model_push();
        exp_t       e;
        int         slot, idx;
        bit         phase, vis, pwm;
        logic [3:0] code;
        if (rst) begin
            e.seg = 7'h00; e.dp = 1'b0; e.sel = '0; e.fs = 1'b0;
            e.seg_al = 7'h7F; e.dp_al = 1'b1; e.sel_al = '1; e.fs_al = 1'b0;
            m_t = 0;
            sh_bcd = '0; sh_dp = '0; sh_blink = '0; sh_bright = '0; sh_lzb = 1'b0;
            last_idx = -1; last_slot = -1; last_fs = 1'b0;
        end else begin
            slot  = m_t % 16;
            idx   = (m_t / 16) % ND;
            phase = (m_t % 256) >= 128;
            if (m_t % 64 == 0) begin
                sh_bcd = bcd; sh_dp = dp_in; sh_blink = blink_mask;
                sh_bright = bright; sh_lzb = lzb_en;
            end
            code = sh_bcd[idx*4 +: 4];
            vis  = 1'b1;
            if (sh_blink[idx] && phase) vis = 1'b0;
            else if (sh_lzb && idx > 0 && (sh_bcd >> (idx*4)) == 16'd0) vis = 1'b0;
            pwm = (slot <= int'(sh_bright));
            e.seg    = (vis && pwm) ? segtab(code, 1'b0) : 7'h00;
            e.dp     = vis && pwm && sh_dp[idx];
            e.sel    = pwm ? ND'(1 << idx) : '0;
            e.fs     = (m_t % 64 == 0);
            e.seg_al = ~((vis && pwm) ? segtab(code, 1'b1) : 7'h00);
            e.dp_al  = ~e.dp;
            e.sel_al = ~e.sel;
            e.fs_al  = e.fs;
            last_idx = idx; last_slot = slot; last_fs = e.fs;
            m_t++;
        end
        sb_q.push_back(e);
    endtask

    // One clock: predict, let the edge happen, compare 1 ns later.
    task automatic cycle();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("seg",       {1'b0, seg},           {1'b0, e.seg});
        chk("dp",        {7'b0, dp},            {7'b0, e.dp});
        chk("sel",       {4'b0, digit_sel},     {4'b0, e.sel});
        chk("fs",        {7'b0, frame_start},   {7'b0, e.fs});
        chk("seg_al",    {1'b0, seg_al},        {1'b0, e.seg_al});
        chk("dp_al",     {7'b0, dp_al},         {7'b0, e.dp_al});
        chk("sel_al",    {4'b0, digit_sel_al},  {4'b0, e.sel_al});
        chk("fs_al",     {7'b0, frame_start_al},{7'b0, e.fs_al});
    endtask

    task automatic wait_fs();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            cycle();
            if (last_fs) got = 1'b1;
        end
        chk("wait_frame_start", {7'b0, got}, 8'd1);
    endtask

    task automatic run_until(input int want_idx, input int want_slot);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            cycle();
            if (last_idx == want_idx && (want_slot < 0 || last_slot == want_slot)) got = 1'b1;
        end
        chk("reach_slot", {7'b0, got}, 8'd1);
    endtask

    // ---------------------------------------------------------------------
    // Vector table: value + hand-derived per-digit patterns {d3,d2,d1,d0}
    // ---------------------------------------------------------------------
    typedef struct packed {
        logic [15:0]     bcd;
        logic            lzb;
        logic [3:0][6:0] dec;
        logic [3:0][6:0] hex;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] b, input logic l,
                                input logic [27:0] d, input logic [27:0] h);
        vec_t v;
        v.bcd = b; v.lzb = l; v.dec = d; v.hex = h;
        return v;
    endfunction

    vec_t vecs [8];

    int n, cnt, cnt_al, on_cnt, off_cnt;

    initial begin
        vecs[0] = mk(16'h1234, 1'b0, {7'h06,7'h5B,7'h4F,7'h66}, {7'h06,7'h5B,7'h4F,7'h66});
        vecs[1] = mk(16'h0007, 1'b1, {7'h00,7'h00,7'h00,7'h07}, {7'h00,7'h00,7'h00,7'h07});
        vecs[2] = mk(16'h0000, 1'b1, {7'h00,7'h00,7'h00,7'h3F}, {7'h00,7'h00,7'h00,7'h3F});
        vecs[3] = mk(16'h0000, 1'b0, {7'h3F,7'h3F,7'h3F,7'h3F}, {7'h3F,7'h3F,7'h3F,7'h3F});
        vecs[4] = mk(16'h00AF, 1'b1, {7'h00,7'h00,7'h00,7'h00}, {7'h00,7'h00,7'h77,7'h71});
        vecs[5] = mk(16'h9080, 1'b1, {7'h6F,7'h3F,7'h7F,7'h3F}, {7'h6F,7'h3F,7'h7F,7'h3F});
        vecs[6] = mk(16'hBCDE, 1'b0, {7'h00,7'h00,7'h00,7'h00}, {7'h7C,7'h39,7'h5E,7'h79});
        vecs[7] = mk(16'h5678, 1'b0, {7'h6D,7'h7D,7'h07,7'h7F}, {7'h6D,7'h7D,7'h07,7'h7F});

        rst = 1'b1; bcd = 16'h1234; dp_in = '0; blink_mask = '0; bright = 4'd15; lzb_en = 1'b0;
        m_t = 0; last_idx = -1; last_slot = -1; last_fs = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        // Basic scan and frame period.
        wait_fs();
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_fs && n < 200);
        chk("frame_period", 8'(n), 8'd64);

        // Table of display values, one full frame each.
        for (int k = 0; k < 8; k++) begin
            bcd = vecs[k].bcd;
            lzb_en = vecs[k].lzb;
            wait_fs();
            for (int c = 0; c < 64; c++) begin
                if (c > 0) cycle();
                if (last_slot == 0) begin
                    chk("vec_dec", {1'b0, seg}, {1'b0, vecs[k].dec[last_idx]});
                    chk("vec_hex", {1'b0, seg_al}, {1'b0, ~vecs[k].hex[last_idx]});
                end
            end
        end

        // Brightness 3: 4 of 16 cycles per slot.
        bcd = 16'h1234; lzb_en = 1'b0; bright = 4'd3;
        wait_fs();
        cnt = (digit_sel != '0) ? 1 : 0;
        cnt_al = (digit_sel_al != '1) ? 1 : 0;
        for (int c = 0; c < 63; c++) begin
            cycle();
            if (digit_sel != '0) cnt++;
            if (digit_sel_al != '1) cnt_al++;
        end
        chk("pwm_on_cycles", 8'(cnt), 8'd16);
        chk("pwm_on_cycles_al", 8'(cnt_al), 8'd16);
        bright = 4'd15;

        // Shadow latching: change mid-frame while digit 1 is active.
        wait_fs();
        run_until(1, -1);
        bcd = 16'h5678;
        run_until(2, 0);
        chk("shadow_hold", {1'b0, seg}, 8'h5B);
        wait_fs();
        chk("shadow_new", {1'b0, seg}, 8'h7F);

        // Blink and decimal point on digit 2.
        bcd = 16'h1234; blink_mask = 4'b0100; dp_in = 4'b0100;
        wait_fs();
        on_cnt = 0; off_cnt = 0;
        for (int c = 0; c < 512; c++) begin
            cycle();
            if (last_idx == 2) begin
                if (dp === 1'b1) on_cnt++;
                else off_cnt++;
            end
        end
        chk("blink_dp_on", 8'(on_cnt), 8'd64);
        chk("blink_dp_off", 8'(off_cnt), 8'd64);

        // Reset mid-slot.
        run_until(2, 7);
        rst = 1'b1;
        cycle();
        chk("rst_seg_al", {1'b0, seg_al}, 8'h7F);
        chk("rst_dp_al", {7'b0, dp_al}, 8'd1);
        chk("rst_sel_al", {4'b0, digit_sel_al}, 8'h0F);
        chk("rst_sel", {4'b0, digit_sel}, 8'h00);
        rst = 1'b0;
        cycle();
        chk("rel_sel_al", {4'b0, digit_sel_al}, 8'h0E);
        chk("rel_fs", {7'b0, frame_start}, 8'd1);
        chk("rel_fs_al", {7'b0, frame_start_al}, 8'd1);
        for (int c = 0; c < 70; c++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
